mc_seq: RTL

Multi-cycle instruction sequencer for the LoongArch multi-cycle core. It owns the architectural PC, the instruction register, and the IF/ID/EXE/MEM/WB state machine. It talks to instruction and data memory over variable-latency req/ready handshakes with a bounded-wait timeout, and pulses register-file write and retire strobes. It sits between the memory interfaces and the existing decoder/ALU/regfile datapath, and replaces the fixed-latency SRAM sequencing of the previous generation.

---
 rtl/mc_pkg.sv | 25 ++
 rtl/mc_seq_if.sv | 32 +++
 rtl/mc_wait_timer.sv | 47 ++++
 rtl/mc_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_pkg
//  Description : Shared definitions for the multi-cycle sequencer.
//                It holds the state encoding, the default reset PC and
//                the sequential PC increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

    // The debug port exposes these encodings, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EXE = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4,
        ST_ERR = 3'd5
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

endpackage
`default_nettype wire

// File: rtl/mc_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mc_seq_if
//  Description : Instruction and data memory handshake bundle.
//                master : sequencer side (drives req/addr/we)
//                slave  : memory side (drives ready/rdata)
//  Signals     : inst_req, inst_addr[31:0], inst_ready, inst_rdata[31:0],
//                data_req, data_we, data_ready
//  Revision    : 1.0 - initial release
// ============================================================================
interface mc_seq_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ready;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_we;
    logic        data_ready;

    modport master (
        output inst_req, inst_addr, data_req, data_we,
        input  inst_ready, inst_rdata, data_ready
    );

    modport slave (
        input  inst_req, inst_addr, data_req, data_we,
        output inst_ready, inst_rdata, data_ready
    );

endinterface
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mc_wait_timer
//  Description : Bounded-wait counter for a pending memory request.
//                It counts the cycles in which a request is pending.
//                'expired' is raised when a pending cycle occurs with the
//                count already at MAX_WAIT. MAX_WAIT=0 disables the timer.
//  Ports       : clk, reset (sync, active-high), clr, pending -> expired
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_wait_timer #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clr,
    input  wire logic pending,
    output logic      expired
);

    generate
        if (MAX_WAIT == 0) begin : g_off
            logic w_unused;
            assign w_unused = &{1'b0, clk, reset, clr, pending};
            assign expired  = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(MAX_WAIT + 1);
            localparam logic [CW-1:0] C_LIMIT = CW'(MAX_WAIT);

            logic [CW-1:0] r_cnt;

            // The sequencer leaves the waiting state in the cycle the count
            // hits the limit, so saturating here only guards against wrap.
            always_ff @(posedge clk) begin
                if (reset || clr) begin
                    r_cnt <= '0;
                end else if (pending && (r_cnt != C_LIMIT)) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            assign expired = pending && (r_cnt == C_LIMIT);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mc_seq
//  Description : Multi-cycle instruction sequencer. It owns PC, IR and the
//                IF/ID/EXE/MEM/WB/ERR state machine. It handshakes with
//                variable-latency instruction and data memories under a
//                bounded-wait timeout.
//  Ports       : clk, reset (sync, active-high), hold
//                bus        : mc_seq_if.master (inst/data handshakes)
//                is_load, is_store, is_br_only, gr_we, br_taken,
//                br_target  : decode results from the datapath
//                ir, pc, state, rf_we, retire, bus_err : outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_seq
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned MAX_WAIT = 255
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        hold,
    mc_seq_if.master         bus,
    input  wire logic        is_load,
    input  wire logic        is_store,
    input  wire logic        is_br_only,
    input  wire logic        gr_we,
    input  wire logic        br_taken,
    input  wire logic [31:0] br_target,
    output logic      [31:0] ir,
    output logic      [31:0] pc,
    output logic      [2:0]  state,
    output logic             rf_we,
    output logic             retire,
    output logic             bus_err
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_bus_err;
    logic        r_inst_pend;   // fetch raised and not yet answered

    logic        w_inst_req;
    logic        w_data_req;
    logic        w_pending;
    logic        w_expired;
    logic        w_timer_clr;
    logic        w_retire;
    logic        w_rf_we;

    // The request terms sit outside the FSM process because they feed the
    // timer, whose 'expired' output in turn steers the next state.
    // Once a fetch has been raised, 'hold' is ignored until it completes.
    assign w_inst_req = (r_state == ST_IF) && (!hold || r_inst_pend);
    assign w_data_req = (r_state == ST_MEM);
    assign w_pending  = (w_inst_req && !bus.inst_ready) ||
                        (w_data_req && !bus.data_ready);

    // -------------------------------------------------------------------
    // Next state and strobes
    // -------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_rf_we     = 1'b0;

        case (r_state)
            ST_IF: begin
                if (w_inst_req) begin
                    if (bus.inst_ready) begin
                        w_state_nxt = ST_ID;
                    end else if (w_expired) begin
                        w_state_nxt = ST_ERR;
                    end
                end
            end
            ST_ID: begin
                if (is_br_only) begin
                    w_retire    = 1'b1;
                    w_state_nxt = ST_IF;
                end else begin
                    w_state_nxt = ST_EXE;
                end
            end
            ST_EXE: begin
                w_state_nxt = (is_load || is_store) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (bus.data_ready) begin
                    if (is_store) begin
                        w_retire    = 1'b1;
                        w_state_nxt = ST_IF;
                    end else begin
                        w_state_nxt = ST_WB;
                    end
                end else if (w_expired) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_WB: begin
                w_rf_we     = gr_we;
                w_retire    = 1'b1;
                w_state_nxt = ST_IF;
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt = ST_ERR;
            end
        endcase

        // A reset cycle aborts the instruction in flight without side effects.
        if (reset) begin
            w_retire = 1'b0;
            w_rf_we  = 1'b0;
        end
    end

    // Counting restarts whenever a new wait phase (fetch or data) begins.
    assign w_timer_clr = (w_state_nxt != r_state) &&
                         ((w_state_nxt == ST_IF) || (w_state_nxt == ST_MEM));

    mc_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_timer_clr),
        .pending (w_pending),
        .expired (w_expired)
    );

    // -------------------------------------------------------------------
    // State register and architectural registers
    // -------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IF;
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_bus_err   <= 1'b0;
            r_inst_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bus_err   <= r_bus_err || (w_state_nxt == ST_ERR);
            r_inst_pend <= w_inst_req && !bus.inst_ready &&
                           (w_state_nxt == ST_IF);
            if (w_inst_req && bus.inst_ready) begin
                r_ir <= bus.inst_rdata;
            end
            if (w_retire) begin
                r_pc <= br_taken ? br_target : (r_pc + PC_STEP);
            end
        end
    end

    // -------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------
    assign bus.inst_req  = w_inst_req && !reset;
    assign bus.inst_addr = r_pc;
    assign bus.data_req  = w_data_req && !reset;
    assign bus.data_we   = w_data_req && is_store && !reset;

    assign ir      = r_ir;
    assign pc      = r_pc;
    assign state   = r_state;
    assign rf_we   = w_rf_we;
    assign retire  = w_retire;
    assign bus_err = r_bus_err;

endmodule
`default_nettype wire
